// File: rtl/sru_dcscmd_exec_pkg.sv
// sru_dcscmd_pkg: shared types and default constants for the DCS command
// executor (state encoding, bus-timeout defaults, read-flag bit position).
package sru_dcscmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RPL_A,
        ST_RPL_D,
        ST_HOLD
    } state_t;

    localparam logic [31:0] ERR_WORD_DEF = 32'hDEAD_BEEF;
    // Must stay below 240 so a read always completes inside the parser's
    // 250-cycle read window.
    localparam int unsigned TIMEOUT_DEF  = 200;
    localparam int unsigned RD_BIT       = 31;

endpackage

// File: rtl/sru_dcscmd_exec_if.sv
// sru_dcscmd_exec_if: SRU internal register bus plus UDP reply FIFO write
// port. The executor uses the master modport; the bus/FIFO side uses slave.
interface sru_dcscmd_exec_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [31:0]       reg_rdata;
    logic              reg_ack;
    logic              reply_wr_en;
    logic [31:0]       reply_wr_data;
    logic              reply_full;

    modport master (
        output reg_addr, reg_wdata, reg_wr, reg_rd,
        input  reg_rdata, reg_ack,
        output reply_wr_en, reply_wr_data,
        input  reply_full
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_wr, reg_rd,
        output reg_rdata, reg_ack,
        input  reply_wr_en, reply_wr_data,
        output reply_full
    );
endinterface

// File: rtl/sru_dcscmd_exec_timeout.sv
// sru_dcscmd_timeout: bus wait counter. Cleared by load, counts while en,
// and stops at TIMEOUT with expired held high until the next load.
module sru_dcscmd_timeout
    import sru_dcscmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic gclk_40m,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Wait counter: restart on load, advance while waiting, freeze at limit.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/sru_dcscmd_exec.sv
// sru_dcscmd_exec: executes one register-bus transaction per rising edge of
// udp_cmd_dv and returns {address, data} to the UDP reply FIFO for reads.
// Build option: define SRU_DCSCMD_WRITE_ACK_EN to also return a reply pair
// (address, echoed write data or error word) for write commands.
module sru_dcscmd_exec
    import sru_dcscmd_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter logic [31:0] ERR_WORD = ERR_WORD_DEF
) (
    input  logic                    gclk_40m,
    input  logic                    reset_n,
    input  logic                    udp_cmd_dv,
    input  logic [31:0]             udp_cmd_addr,
    input  logic [31:0]             udp_cmd_data,
    output logic                    udp_reply_stored,
    sru_dcscmd_exec_if.master       bus,
    output logic                    busy,
    output logic [15:0]             timeout_cnt
);

`ifdef SRU_DCSCMD_WRITE_ACK_EN
    localparam logic WRITE_ACK = 1'b1;
`else
    localparam logic WRITE_ACK = 1'b0;
`endif

    state_t      state;
    state_t      state_nxt;
    logic        dv_q;
    logic        cmd_edge;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] rdat;
    logic        is_rd;
    logic        wait_load;
    logic        wait_en;
    logic        wait_expired;

    assign cmd_edge  = udp_cmd_dv & ~dv_q;
    assign is_rd     = cmd_addr[RD_BIT];
    assign wait_load = (state == ST_REQ);
    assign wait_en   = (state == ST_WAIT);

    sru_dcscmd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .gclk_40m (gclk_40m),
        .reset_n  (reset_n),
        .load     (wait_load),
        .en       (wait_en),
        .expired  (wait_expired)
    );

    // State register.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack in the timeout cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (cmd_edge) state_nxt = ST_REQ;
            ST_REQ:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.reg_ack || wait_expired) begin
                    state_nxt = (is_rd || WRITE_ACK) ? ST_RPL_A : ST_HOLD;
                end
            end
            ST_RPL_A: if (!bus.reply_full) state_nxt = ST_RPL_D;
            ST_RPL_D: if (!bus.reply_full) state_nxt = ST_HOLD;
            ST_HOLD:  if (!udp_cmd_dv) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Combinational outputs: busy flag and FIFO write gated by full.
    always_comb begin
        busy              = (state != ST_IDLE);
        bus.reply_wr_en   = 1'b0;
        bus.reply_wr_data = '0;
        if (state == ST_RPL_A) begin
            bus.reply_wr_en   = !bus.reply_full;
            bus.reply_wr_data = cmd_addr;
        end else if (state == ST_RPL_D) begin
            bus.reply_wr_en   = !bus.reply_full;
            bus.reply_wr_data = rdat;
        end
    end

    // Command latch, bus strobes, reply data capture and status flags.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            dv_q             <= 1'b0;
            cmd_addr         <= '0;
            cmd_data         <= '0;
            rdat             <= '0;
            bus.reg_addr     <= '0;
            bus.reg_wdata    <= '0;
            bus.reg_rd       <= 1'b0;
            bus.reg_wr       <= 1'b0;
            udp_reply_stored <= 1'b0;
            timeout_cnt      <= '0;
        end else begin
            dv_q       <= udp_cmd_dv;
            bus.reg_rd <= (state == ST_REQ) &&  is_rd;
            bus.reg_wr <= (state == ST_REQ) && !is_rd;

            if (state == ST_IDLE && cmd_edge) begin
                cmd_addr      <= udp_cmd_addr;
                cmd_data      <= udp_cmd_data;
                bus.reg_addr  <= udp_cmd_addr[ADDR_W-1:0];
                bus.reg_wdata <= udp_cmd_data;
            end

            if (state == ST_WAIT) begin
                if (bus.reg_ack) begin
                    rdat <= is_rd ? bus.reg_rdata : cmd_data;
                end else if (wait_expired) begin
                    rdat <= ERR_WORD;
                    if (timeout_cnt != 16'hFFFF) begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
            end

            if (state == ST_RPL_D && !bus.reply_full) begin
                udp_reply_stored <= 1'b1;
            end else if (state == ST_HOLD && !udp_cmd_dv) begin
                udp_reply_stored <= 1'b0;
            end
        end
    end

endmodule
